// File: rtl/mem_line_responder_pkg.sv
// Shared definitions for the line-fill memory responder: FSM states, requester ids,
// line-offset width and small helpers used by the responder and its storage.
package mem_line_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } stateT;

    // Values double as indices into per-requester vectors.
    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } reqIdT;

    localparam int LINE_OFFSET_BITS = 4;

    function automatic reqIdT otherReq(input reqIdT id);
        return (id == REQ_DC) ? REQ_IC : REQ_DC;
    endfunction

    // A latency of 1 still needs a one-bit counter.
    function automatic int counterWidth(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/mem_line_responder_if.sv
// Line-fill bus between the iCache/dCache requesters (master) and the memory
// responder (slave): two req/ack ports plus the responder busy flag.
interface mem_line_responder_if #(
    parameter int ADDR_WIDTH    = 32,
    parameter int MEM_BUS_WIDTH = 128
);

    logic                     ic_req;
    logic [ADDR_WIDTH-1:0]    ic_addr;
    logic                     ic_ack;
    logic [MEM_BUS_WIDTH-1:0] ic_rdata;

    logic                     dc_req;
    logic                     dc_we;
    logic [ADDR_WIDTH-1:0]    dc_addr;
    logic [MEM_BUS_WIDTH-1:0] dc_wdata;
    logic                     dc_ack;
    logic [MEM_BUS_WIDTH-1:0] dc_rdata;

    logic                     busy;

    modport master (
        output ic_req, ic_addr,
        output dc_req, dc_we, dc_addr, dc_wdata,
        input  ic_ack, ic_rdata,
        input  dc_ack, dc_rdata,
        input  busy
    );

    modport slave (
        input  ic_req, ic_addr,
        input  dc_req, dc_we, dc_addr, dc_wdata,
        output ic_ack, ic_rdata,
        output dc_ack, dc_rdata,
        output busy
    );

endinterface

// File: rtl/mem_line_array.sv
// Single-port line storage, MEM_BUS_WIDTH x 2**LINE_IDX_BITS, with a registered read
// port. Contents are deliberately not reset so the array maps onto block RAM.
module mem_line_array #(
    parameter int MEM_BUS_WIDTH = 128,
    parameter int LINE_IDX_BITS = 10
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [LINE_IDX_BITS-1:0] idx,
    input  logic [MEM_BUS_WIDTH-1:0] wdata,
    output logic [MEM_BUS_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << LINE_IDX_BITS;

    logic [MEM_BUS_WIDTH-1:0] lines [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                lines[idx] <= wdata;
            end else begin
                rdata <= lines[idx];
            end
        end
    end

endmodule

// File: rtl/mem_line_responder.sv
// Main-memory line responder: arbitrates iCache/dCache line requests, applies a fixed
// latency and returns one ack per request. Define MEM_RESP_RR_ARB_EN for round-robin
// arbitration; otherwise the dCache always wins a tie.
module mem_line_responder
    import mem_line_responder_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int MEM_BUS_WIDTH = 128,
    parameter int LINE_IDX_BITS = 10,
    parameter int MEM_LATENCY   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_line_responder_if.slave   bus
);

    localparam int CNT_W = counterWidth(MEM_LATENCY);

    stateT                    stateReg;
    reqIdT                    winnerReg;
    logic                     weReg;
    logic [LINE_IDX_BITS-1:0] idxReg;
    logic [MEM_BUS_WIDTH-1:0] wdataReg;
    logic [CNT_W-1:0]         cntReg;
    logic                     icAckReg;
    logic                     dcAckReg;
    logic [MEM_BUS_WIDTH-1:0] icRdataReg;
    logic [MEM_BUS_WIDTH-1:0] dcRdataReg;
    logic                     busyReg;
`ifdef MEM_RESP_RR_ARB_EN
    reqIdT                    rrPtrReg;
`endif

    logic [ADDR_WIDTH-1:0]    addrVec [2];
    logic [LINE_IDX_BITS-1:0] idxVec  [2];
    logic                     anyReq;
    reqIdT                    grantId;
    logic                     grantWe;
    logic                     lastBusyCycle;

    logic                     arrEn;
    logic                     arrWe;
    logic [LINE_IDX_BITS-1:0] arrIdx;
    logic [MEM_BUS_WIDTH-1:0] arrRdata;

    // Offset and upper address bits are ignored on purpose: lines alias modulo the array.
    logic                     unusedAddrBits;

    assign addrVec[REQ_IC] = bus.ic_addr;
    assign addrVec[REQ_DC] = bus.dc_addr;
    assign unusedAddrBits  = ^{bus.ic_addr, bus.dc_addr};

    for (genvar gi = 0; gi < 2; gi++) begin : gLineIdx
        assign idxVec[gi] = addrVec[gi][LINE_IDX_BITS+LINE_OFFSET_BITS-1 -: LINE_IDX_BITS];
    end

    assign anyReq = bus.ic_req | bus.dc_req;

`ifdef MEM_RESP_RR_ARB_EN
    assign grantId = (bus.ic_req && bus.dc_req) ? rrPtrReg
                   : (bus.dc_req ? REQ_DC : REQ_IC);
`else
    assign grantId = bus.dc_req ? REQ_DC : REQ_IC;
`endif

    assign grantWe       = (grantId == REQ_DC) && bus.dc_we;
    assign lastBusyCycle = (stateReg == BUSY) && (cntReg == '0);

    // The line is read speculatively at the accepting edge; nothing else can touch the
    // array while this request is in flight, so the value is still current at the ack.
    // Writes commit only on the last BUSY edge, so a reset before then drops them.
    always_comb begin
        arrEn  = 1'b0;
        arrWe  = 1'b0;
        arrIdx = idxReg;
        if ((stateReg == IDLE) && anyReq) begin
            arrEn  = 1'b1;
            arrIdx = idxVec[grantId];
        end else if (lastBusyCycle && weReg) begin
            arrEn  = 1'b1;
            arrWe  = 1'b1;
        end
    end

    mem_line_array #(
        .MEM_BUS_WIDTH (MEM_BUS_WIDTH),
        .LINE_IDX_BITS (LINE_IDX_BITS)
    ) uArray (
        .clk   (clk),
        .en    (arrEn),
        .we    (arrWe),
        .idx   (arrIdx),
        .wdata (wdataReg),
        .rdata (arrRdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg   <= IDLE;
            winnerReg  <= REQ_DC;
            weReg      <= 1'b0;
            idxReg     <= '0;
            wdataReg   <= '0;
            cntReg     <= '0;
            icAckReg   <= 1'b0;
            dcAckReg   <= 1'b0;
            icRdataReg <= '0;
            dcRdataReg <= '0;
            busyReg    <= 1'b0;
`ifdef MEM_RESP_RR_ARB_EN
            rrPtrReg   <= REQ_DC;
`endif
        end else begin
            icAckReg <= 1'b0;
            dcAckReg <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (anyReq) begin
                        winnerReg <= grantId;
                        idxReg    <= idxVec[grantId];
                        weReg     <= grantWe;
                        wdataReg  <= bus.dc_wdata;
                        cntReg    <= CNT_W'(MEM_LATENCY - 1);
                        stateReg  <= BUSY;
                        busyReg   <= 1'b1;
`ifdef MEM_RESP_RR_ARB_EN
                        rrPtrReg  <= otherReq(grantId);
`endif
                    end
                end
                BUSY: begin
                    if (cntReg == '0) begin
                        stateReg <= RESP;
                        if (winnerReg == REQ_IC) begin
                            icAckReg   <= 1'b1;
                            icRdataReg <= arrRdata;
                        end else begin
                            dcAckReg   <= 1'b1;
                            dcRdataReg <= weReg ? wdataReg : arrRdata;
                        end
                    end else begin
                        cntReg <= cntReg - 1'b1;
                    end
                end
                RESP: begin
                    stateReg <= IDLE;
                    busyReg  <= 1'b0;
                end
                default: begin
                    stateReg <= IDLE;
                    busyReg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ic_ack   = icAckReg;
    assign bus.ic_rdata = icRdataReg;
    assign bus.dc_ack   = dcAckReg;
    assign bus.dc_rdata = dcRdataReg;
    assign bus.busy     = busyReg;

endmodule

// File: tb/tb_mem_line_responder.sv
// Randomized scoreboard bench for mem_line_responder: a transaction-level memory model
// predicts which port acks, when, and with which line; a monitor compares on every ack.
`timescale 1ns/1ps
module tb_mem_line_responder;

    localparam int AW     = 32;
    localparam int DW     = 128;
    localparam int LIB    = 10;
    localparam int LAT    = 4;
    localparam int NLINES = 8;
    localparam int NRAND  = 60;
    localparam int TMO    = 200;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mem_line_responder_if #(.ADDR_WIDTH(AW), .MEM_BUS_WIDTH(DW)) bus  ();
    mem_line_responder_if #(.ADDR_WIDTH(AW), .MEM_BUS_WIDTH(DW)) bus1 ();

    mem_line_responder #(
        .ADDR_WIDTH(AW), .MEM_BUS_WIDTH(DW), .LINE_IDX_BITS(LIB), .MEM_LATENCY(LAT)
    ) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    mem_line_responder #(
        .ADDR_WIDTH(AW), .MEM_BUS_WIDTH(DW), .LINE_IDX_BITS(LIB), .MEM_LATENCY(1)
    ) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct {
        bit          isDc;
        bit          isWr;
        int          idx;
        logic [DW-1:0] data;
        int          ackCyc;
    } expT;

    int            nChecks = 0;
    int            nFails  = 0;
    int            cyc     = 0;
    int            freeAt  = 0;
    int            lastAcc = -100;
    logic [DW-1:0] refMem [0:(1<<LIB)-1];
    logic [DW-1:0] expIcData = '0;
    logic [DW-1:0] expDcData = '0;
    expT           sbq [$];
    expT           mE;
    bit            mDcWins;
`ifdef MEM_RESP_RR_ARB_EN
    bit            rrPtrDc = 1'b1;
`endif

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] want);
        nChecks++;
        if (act !== want) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic logic [AW-1:0] mkAddr(input int line);
        logic [AW-1:0] a;
        a = $urandom;
        a[LIB+3:4] = line[LIB-1:0];
        return a;
    endfunction

    function automatic logic [DW-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: the memory serves one request at a time, taking 1 idle + LAT busy +
    // 1 response cycle; a request seen at edge c is answered after edge c+LAT.
    initial forever begin
        @(clk);
        if (clk) begin
            cyc++;
            if (!rst_n) begin
                sbq.delete();
                freeAt  = 0;
                lastAcc = -100;
`ifdef MEM_RESP_RR_ARB_EN
                rrPtrDc = 1'b1;
`endif
            end else if (cyc >= freeAt && (bus.ic_req || bus.dc_req)) begin
`ifdef MEM_RESP_RR_ARB_EN
                mDcWins = bus.dc_req && (!bus.ic_req || rrPtrDc);
                rrPtrDc = !mDcWins;
`else
                mDcWins = bus.dc_req;
`endif
                mE.isDc   = mDcWins;
                mE.isWr   = mDcWins && bus.dc_we;
                mE.idx    = int'(mDcWins ? bus.dc_addr[LIB+3:4] : bus.ic_addr[LIB+3:4]);
                mE.data   = mE.isWr ? bus.dc_wdata : refMem[mE.idx];
                mE.ackCyc = cyc + LAT;
                sbq.push_back(mE);
                freeAt  = cyc + LAT + 2;
                lastAcc = cyc;
            end
        end else if (!rst_n) begin
            expIcData = '0;
            expDcData = '0;
        end else begin
            check("ack_exclusive", bus.ic_ack & bus.dc_ack, 1'b0);
            if (bus.ic_ack || bus.dc_ack) begin
                check("ack_was_expected", sbq.size() != 0, 1'b1);
                if (sbq.size() != 0) begin
                    mE = sbq.pop_front();
                    check("ack_port_is_dc", bus.dc_ack, mE.isDc);
                    check("ack_cycle", cyc, mE.ackCyc);
                    if (mE.isDc) expDcData = mE.data;
                    else         expIcData = mE.data;
                    if (mE.isWr) refMem[mE.idx] = mE.data;
                    $display("txn %s %s line %0d data=%h ack_cyc=%0d",
                             mE.isDc ? "DC" : "IC", mE.isWr ? "WR" : "RD", mE.idx, mE.data, cyc);
                end
            end else if (sbq.size() != 0 && sbq[0].ackCyc < cyc) begin
                check("ack_missing_cycle", cyc, sbq[0].ackCyc);
                void'(sbq.pop_front());
            end
            check("ic_rdata", bus.ic_rdata, expIcData);
            check("dc_rdata", bus.dc_rdata, expDcData);
            check("busy", bus.busy, (cyc >= lastAcc) && (cyc <= lastAcc + LAT));
        end
    end

    task automatic icIssue(input logic [AW-1:0] addr);
        int t = 0;
        bus.ic_addr = addr;
        bus.ic_req  = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.ic_ack && t < TMO);
        check("ic_ack_within_bound", bus.ic_ack, 1'b1);
        bus.ic_req = 1'b0;
    endtask

    task automatic dcIssue(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        int t = 0;
        bus.dc_we    = we;
        bus.dc_addr  = addr;
        bus.dc_wdata = wd;
        bus.dc_req   = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.dc_ack && t < TMO);
        check("dc_ack_within_bound", bus.dc_ack, 1'b1);
        bus.dc_req = 1'b0;
    endtask

    // One request on the MEM_LATENCY=1 instance, observed edge by edge from the raise.
    task automatic lat1Txn(input bit isDc, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, output int ackEdge, output int ackCount,
                           output int busyCycles, output logic [DW-1:0] rd);
        ackEdge = -1; ackCount = 0; busyCycles = 0; rd = '0;
        if (isDc) begin
            bus1.dc_we = we; bus1.dc_addr = addr; bus1.dc_wdata = wd; bus1.dc_req = 1'b1;
        end else begin
            bus1.ic_addr = addr; bus1.ic_req = 1'b1;
        end
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            if (bus1.busy) busyCycles++;
            if (bus1.ic_ack || bus1.dc_ack) begin
                ackCount++;
                ackEdge = e;
                rd = isDc ? bus1.dc_rdata : bus1.ic_rdata;
                bus1.ic_req = 1'b0;
                bus1.dc_req = 1'b0;
            end
        end
        bus1.ic_req = 1'b0;
        bus1.dc_req = 1'b0;
        $display("txn LAT1 %s %s ack_edge=%0d busy_cycles=%0d data=%h",
                 isDc ? "DC" : "IC", we ? "WR" : "RD", ackEdge, busyCycles, rd);
    endtask

    initial begin
        #(200000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            ackEdge, ackCount, busyCycles;
        logic [DW-1:0] rd, wd;

        bus.ic_req = 1'b0;  bus.ic_addr = '0;
        bus.dc_req = 1'b0;  bus.dc_we = 1'b0; bus.dc_addr = '0; bus.dc_wdata = '0;
        bus1.ic_req = 1'b0; bus1.ic_addr = '0;
        bus1.dc_req = 1'b0; bus1.dc_we = 1'b0; bus1.dc_addr = '0; bus1.dc_wdata = '0;

        #2 rst_n = 1'b0;
        #1;
        check("reset_ic_ack",   bus.ic_ack,   1'b0);
        check("reset_dc_ack",   bus.dc_ack,   1'b0);
        check("reset_ic_rdata", bus.ic_rdata, '0);
        check("reset_dc_rdata", bus.dc_rdata, '0);
        check("reset_busy",     bus.busy,     1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NLINES; i++) dcIssue(1'b1, mkAddr(i), rand128());

        // Writeback then a fill of the same line at a different offset.
        dcIssue(1'b1, 32'h0000_0040, 128'h1111_3333_5555_7777_9999_BBBB_DDDD_FFFF);
        icIssue(32'h0000_0048);

        // Index wraps: 0x4010 and 0x0010 are the same line.
        dcIssue(1'b1, 32'h0000_4010, rand128());
        icIssue(32'h0000_0010);

        // Simultaneous requests: the loser is served right after the winner.
        fork
            icIssue(mkAddr(2));
            dcIssue(1'b0, mkAddr(3), rand128());
        join

        fork
            for (int k = 0; k < NRAND; k++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                icIssue(mkAddr($urandom_range(0, NLINES - 1)));
            end
            for (int k = 0; k < NRAND; k++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                dcIssue(1'($urandom_range(0, 1)), mkAddr($urandom_range(0, NLINES - 1)), rand128());
            end
        join
        repeat (LAT + 4) @(negedge clk);

        // Reset in the middle of a write: outputs clear at once, the line keeps its old data.
        bus.dc_we = 1'b1; bus.dc_addr = mkAddr(5); bus.dc_wdata = rand128(); bus.dc_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3;
        check("busy_before_reset", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midreset_ic_ack",   bus.ic_ack,   1'b0);
        check("midreset_dc_ack",   bus.dc_ack,   1'b0);
        check("midreset_ic_rdata", bus.ic_rdata, '0);
        check("midreset_dc_rdata", bus.dc_rdata, '0);
        check("midreset_busy",     bus.busy,     1'b0);
        bus.dc_req = 1'b0;
        bus.dc_we  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        icIssue(mkAddr(5));
        repeat (LAT + 4) @(negedge clk);

        // MEM_LATENCY=1: accept on edge 1, ack visible after edge 2, busy for 2 cycles.
        wd = rand128();
        lat1Txn(1'b1, 1'b1, 32'h0000_0030, wd, ackEdge, ackCount, busyCycles, rd);
        check("lat1_wr_ack_edge",    ackEdge,    2);
        check("lat1_wr_ack_count",   ackCount,   1);
        check("lat1_wr_busy_cycles", busyCycles, 2);
        check("lat1_wr_rdata",       rd,         wd);
        lat1Txn(1'b0, 1'b0, 32'h0000_0034, '0, ackEdge, ackCount, busyCycles, rd);
        check("lat1_rd_ack_edge",    ackEdge,    2);
        check("lat1_rd_ack_count",   ackCount,   1);
        check("lat1_rd_busy_cycles", busyCycles, 2);
        check("lat1_rd_rdata",       rd,         wd);

        repeat (LAT + 4) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
